instr_encoder: RTL and testbench

Instruction encoder that packs RV32I instruction fields and a 32-bit immediate into a 32-bit instruction word, the inverse of the core's immediate generator. Each encoded word is written to instruction memory at an auto-incrementing address. The block range-checks and alignment-checks every immediate before writing. It sits between the debug/boot loader front end and the instruction memory write port.

---
 rtl/instr_encoder.sv | 160 ++++++++++++++++
 tb/tb_instr_encoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs instruction fields and a byte-offset immediate into a
// 32-bit word after range/alignment checks, then writes it at an auto-incrementing address.
module instr_encoder #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load_base,
   input  logic [31:0]      base_addr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_imm_op,
   input  logic [6:0]       in_opcode,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [2:0]       in_funct3,
   input  logic [6:0]       in_funct7,
   input  logic [31:0]      in_imm,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic             mem_ready,
   output logic             busy,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [1:0] {StIdle, StPack, StWrite} state_e;

   state_e      state_q, state_d;
   logic [2:0]  imm_op_q;
   logic [6:0]  opcode_q;
   logic [4:0]  rd_q, rs1_q, rs2_q;
   logic [2:0]  funct3_q;
   logic [6:0]  funct7_q;
   logic [31:0] imm_q;

   logic        chk_illegal, chk_range, chk_align, pack_err;
   logic [1:0]  pack_code;
   logic [31:0] pack_word;
   logic        hs;

   assign in_ready = (state_q == StIdle) & en & ~load_base;
   assign hs       = in_valid & in_ready;
   assign mem_we   = (state_q == StWrite);
   assign busy     = (state_q != StIdle);

   // Range checks: the bits above the encodable field must be a pure sign extension.
   always_comb begin
      pack_word   = '0;
      chk_illegal = 1'b0;
      chk_range   = 1'b0;
      chk_align   = 1'b0;
      case (imm_op_q)
         3'd0: pack_word = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
         3'd1: begin
            chk_range = ~(&imm_q[31:11] | ~|imm_q[31:11]);
            pack_word = {imm_q[11:0], rs1_q, funct3_q, rd_q, opcode_q};
         end
         3'd2: begin
            chk_range = ~(&imm_q[31:11] | ~|imm_q[31:11]);
            pack_word = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_q};
         end
         3'd3: begin
            chk_range = ~(&imm_q[31:12] | ~|imm_q[31:12]);
            chk_align = imm_q[0];
            pack_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q, imm_q[4:1],
                         imm_q[11], opcode_q};
         end
         3'd4: begin
            chk_align = |imm_q[11:0];
            pack_word = {imm_q[31:12], rd_q, opcode_q};
         end
         3'd5: begin
            chk_range = ~(&imm_q[31:20] | ~|imm_q[31:20]);
            chk_align = imm_q[0];
            pack_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, opcode_q};
         end
         default: chk_illegal = 1'b1;
      endcase
   end

   assign pack_err  = chk_illegal | chk_range | chk_align;
   assign pack_code = chk_illegal ? 2'd3 : chk_range ? 2'd1 : chk_align ? 2'd2 : 2'd0;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (!load_base && hs) state_d = StPack;
         StPack:  state_d = pack_err ? StIdle : StWrite;
         StWrite: if (mem_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         imm_op_q    <= '0;
         opcode_q    <= '0;
         rd_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         funct3_q    <= '0;
         funct7_q    <= '0;
         imm_q       <= '0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         err         <= 1'b0;
         err_code    <= '0;
         instr_count <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (load_base) begin
                  mem_addr <= base_addr;
                  err      <= 1'b0;
                  err_code <= '0;
               end else if (hs) begin
                  imm_op_q <= in_imm_op;
                  opcode_q <= in_opcode;
                  rd_q     <= in_rd;
                  rs1_q    <= in_rs1;
                  rs2_q    <= in_rs2;
                  funct3_q <= in_funct3;
                  funct7_q <= in_funct7;
                  imm_q    <= in_imm;
               end
            end
            StPack: begin
               if (pack_err) begin
                  err <= 1'b1;
                  // err_code records only the first error since the last clear.
                  if (!err) err_code <= pack_code;
               end else begin
                  mem_wdata <= pack_word;
               end
            end
            StWrite: begin
               if (mem_ready) begin
                  mem_addr <= mem_addr + 32'd4;
                  if (!(&instr_count)) instr_count <= instr_count + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand-written corner
// sequences and randomized requests against a field-arithmetic reference model.
module tb_instr_encoder;

   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst, en, load_base, in_valid, in_ready, mem_we, mem_ready, busy, err;
   logic [31:0]      base_addr, in_imm, mem_addr, mem_wdata;
   logic [2:0]       in_imm_op, in_funct3;
   logic [6:0]       in_opcode, in_funct7;
   logic [4:0]       in_rd, in_rs1, in_rs2;
   logic [1:0]       err_code;
   logic [CNT_W-1:0] instr_count;

   instr_encoder #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .en(en), .load_base(load_base), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_imm_op(in_imm_op),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .busy(busy), .err(err), .err_code(err_code), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [6:0]  opcode;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
   } req_t;

   typedef struct {
      bit          clr;
      req_t        r;
      logic [31:0] word;
      logic [1:0]  code;
   } vec_t;

   int n_chk = 0;
   int n_pass = 0;

   // Expected architectural state
   logic [31:0] m_addr;
   logic        m_err;
   logic [1:0]  m_code;
   int          m_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Reference encoder built from the RV32I field layout with shifts and masks.
   function automatic void model(input req_t r, output logic [31:0] w, output logic [1:0] code);
      int signed   s = $signed(r.imm);
      logic [31:0] i = r.imm;
      logic [31:0] regs;
      regs = (32'(r.rs1) << 15) | (32'(r.f3) << 12) | 32'(r.opcode);
      w    = 32'h0;
      code = 2'd0;
      case (r.op)
         3'd0: w = (32'(r.f7) << 25) | (32'(r.rs2) << 20) | regs | (32'(r.rd) << 7);
         3'd1: begin
            if (s < -2048 || s > 2047) code = 2'd1;
            w = ((i & 32'hFFF) << 20) | regs | (32'(r.rd) << 7);
         end
         3'd2: begin
            if (s < -2048 || s > 2047) code = 2'd1;
            w = (((i >> 5) & 32'h7F) << 25) | (32'(r.rs2) << 20) | regs | ((i & 32'h1F) << 7);
         end
         3'd3: begin
            if (s < -4096 || s > 4095) code = 2'd1;
            else if (i[0]) code = 2'd2;
            w = (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3F) << 25) |
                (32'(r.rs2) << 20) | regs | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 32'h1) << 7);
         end
         3'd4: begin
            if ((i & 32'hFFF) != 0) code = 2'd2;
            w = (i & 32'hFFFFF000) | (32'(r.rd) << 7) | 32'(r.opcode);
         end
         3'd5: begin
            if (s < -(1 << 20) || s > (1 << 20) - 1) code = 2'd1;
            else if (i[0]) code = 2'd2;
            w = (((i >> 20) & 32'h1) << 31) | (((i >> 1) & 32'h3FF) << 21) |
                (((i >> 11) & 32'h1) << 20) | (((i >> 12) & 32'hFF) << 12) |
                (32'(r.rd) << 7) | 32'(r.opcode);
         end
         default: code = 2'd3;
      endcase
   endfunction

   task automatic load(input logic [31:0] a);
      @(negedge clk);
      load_base = 1'b1;
      base_addr = a;
      in_valid  = 1'b1;
      #1 check("load_in_ready", in_ready, 0);
      @(posedge clk);
      #1 load_base = 1'b0;
      in_valid = 1'b0;
      m_addr = a;
      m_err  = 1'b0;
      m_code = 2'd0;
      check("load_addr", mem_addr, m_addr);
      check("load_err", err, 0);
      check("load_code", err_code, 0);
      check("load_busy", busy, 0);
   endtask

   // Issues one request; abort=1 returns while the DUT sits in WRITE.
   task automatic run(input req_t r, input logic [31:0] exp_w, input logic [1:0] exp_code,
                      input int stall, input bit abort);
      int n;
      @(negedge clk);
      in_imm_op = r.op;  in_opcode = r.opcode; in_rd = r.rd; in_rs1 = r.rs1;
      in_rs2 = r.rs2;    in_funct3 = r.f3;     in_funct7 = r.f7; in_imm = r.imm;
      in_valid = 1'b1;
      n = 0;
      while (in_ready !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) begin
         check("in_ready_timeout", in_ready, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("pack_busy", busy, 1);
      check("pack_in_ready", in_ready, 0);
      check("pack_we", mem_we, 0);
      @(posedge clk);
      #1;
      if (exp_code != 2'd0) begin
         if (!m_err) m_code = exp_code;
         m_err = 1'b1;
         check("err_we", mem_we, 0);
         check("err_flag", err, m_err);
         check("err_code", err_code, m_code);
         check("err_addr", mem_addr, m_addr);
         check("err_busy", busy, 0);
         check("err_cnt", instr_count, m_cnt);
         return;
      end
      check("wr_we", mem_we, 1);
      check("wr_addr", mem_addr, m_addr);
      check("wr_data", mem_wdata, exp_w);
      if (abort) return;
      for (int k = 0; k < stall; k++) begin
         @(posedge clk);
         #1;
         check("stall_we", mem_we, 1);
         check("stall_addr", mem_addr, m_addr);
         check("stall_data", mem_wdata, exp_w);
         check("stall_in_ready", in_ready, 0);
         check("stall_cnt", instr_count, m_cnt);
      end
      mem_ready = 1'b1;
      @(posedge clk);
      #1 mem_ready = 1'b0;
      m_addr = m_addr + 32'd4;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      check("post_we", mem_we, 0);
      check("post_addr", mem_addr, m_addr);
      check("post_cnt", instr_count, m_cnt);
      check("post_err", err, m_err);
   endtask

   function automatic req_t mk(input logic [2:0] op, input logic [6:0] opc, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm);
      req_t r;
      r.op = op; r.opcode = opc; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
      r.f3 = f3; r.f7 = f7; r.imm = imm;
      return r;
   endfunction

   vec_t        vecs[10];
   req_t        rr;
   logic [31:0] w;
   logic [1:0]  c;

   initial begin
      rst = 1'b1; en = 1'b1; load_base = 1'b0; base_addr = '0; in_valid = 1'b0;
      in_imm_op = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
      in_funct3 = '0; in_funct7 = '0; in_imm = '0; mem_ready = 1'b0;
      m_addr = '0; m_err = 1'b0; m_code = '0; m_cnt = 0;

      vecs[0] = '{1'b0, mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF), 32'hFFF00093, 2'd0};
      vecs[1] = '{1'b0, mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8),        32'h0020A423, 2'd0};
      vecs[2] = '{1'b0, mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC), 32'hFE000EE3, 2'd0};
      vecs[3] = '{1'b0, mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000), 32'h123452B7, 2'd0};
      vecs[4] = '{1'b0, mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800), 32'h001000EF, 2'd0};
      vecs[5] = '{1'b0, mk(3'd0, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'h0),        32'h405201B3, 2'd0};
      vecs[6] = '{1'b0, mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048),     32'h0, 2'd1};
      vecs[7] = '{1'b0, mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3),        32'h0, 2'd2};
      vecs[8] = '{1'b1, mk(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0),        32'h0, 2'd3};
      vecs[9] = '{1'b1, mk(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1001),     32'h0, 2'd2};

      #12;
      check("rst_we", mem_we, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_data", mem_wdata, 0);
      check("rst_err", err, 0);
      check("rst_code", err_code, 0);
      check("rst_cnt", instr_count, 0);
      check("rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("idle_in_ready", in_ready, 1);
      en = 1'b0;
      #1 check("dis_in_ready", in_ready, 0);
      en = 1'b1;

      load(32'h100);
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].clr) load(m_addr);
         run(vecs[i].r, vecs[i].word, vecs[i].code, 0, 1'b0);
      end
      load(m_addr);

      // Backpressure: five stalled cycles, single increment on release.
      run(vecs[5].r, vecs[5].word, 2'd0, 5, 1'b0);

      // Pointer wrap.
      load(32'hFFFFFFFC);
      run(vecs[0].r, vecs[0].word, 2'd0, 0, 1'b0);
      check("wrap_addr", mem_addr, 32'h0);

      // Asynchronous reset while in WRITE.
      run(vecs[1].r, vecs[1].word, 2'd0, 0, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("arst_we", mem_we, 0);
      check("arst_addr", mem_addr, 0);
      check("arst_data", mem_wdata, 0);
      check("arst_cnt", instr_count, 0);
      check("arst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      m_addr = '0; m_err = 1'b0; m_code = '0; m_cnt = 0;
      run(vecs[3].r, vecs[3].word, 2'd0, 0, 1'b0);

      // Randomized requests against the reference model.
      for (int i = 0; i < 150; i++) begin
         rr.op = 3'($urandom_range(0, 7));
         rr.opcode = 7'($urandom); rr.rd = 5'($urandom); rr.rs1 = 5'($urandom);
         rr.rs2 = 5'($urandom); rr.f3 = 3'($urandom); rr.f7 = 7'($urandom);
         case ($urandom_range(0, 3))
            0: rr.imm = $urandom;
            1: rr.imm = 32'($signed(12'($urandom)));
            2: rr.imm = 32'($signed(21'($urandom))) & ~32'h1;
            default: rr.imm = $urandom & 32'hFFFFF000;
         endcase
         if (m_err && $urandom_range(0, 3) == 0) load($urandom);
         model(rr, w, c);
         run(rr, w, c, int'($urandom_range(0, 2)), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
